hbridge_driver: RTL and testbench
=================================

HBRIDGE_DRIVER -- requirements
Module: hbridge_driver

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent motor channels.
REQ-002 SHALL have parameter NBITS, default 9: signed duty width, including sign bit.
REQ-003 SHALL have parameter CLK_DIV, default 1: clk cycles per PWM counter tick (>=1).
REQ-004 SHALL have parameter DEADTIME, default 16: clk cycles of brake inserted on direction reversal (>=1).
REQ-005 SHALL have parameter DIR_INV, default {NCH{1'b0}}: per-channel direction inversion mask.
REQ-006 SHALL have port clk, input, 1: the only clock.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1: global enable; low forces all channels to IDLE.
REQ-009 SHALL have port duty_i, input, NCH*NBITS: per-channel two's-complement duty; channel k at bits [k*NBITS +: NBITS].
REQ-010 SHALL have port brake_i, input, NCH: per-channel brake request.
REQ-011 SHALL have port therm_n_i, input, NCH: LMD18200 thermal flag, active-low, asynchronous.
REQ-012 SHALL have port fault_clr_i, input, NCH: per-channel fault-clear pulse.
REQ-013 SHALL have port pwm_o, output, NCH: PWM to bridge.
REQ-014 SHALL have port dir_o, output, NCH: direction to bridge.
REQ-015 SHALL have port br_o, output, NCH: brake to bridge.
REQ-016 SHALL have port fault_o, output, NCH: sticky thermal-fault flag.

Function
REQ-017 SHALL derive M = 2^(NBITS-1)-1 and run one shared period counter 0..M-1, advancing once per CLK_DIV clk cycles and wrapping to 0.
REQ-018 SHALL compute magnitude |duty|, saturating the most negative code -2^(NBITS-1) to M.
REQ-019 SHALL latch magnitude and sign per channel only when the counter wraps to 0 (period start); mid-period duty changes are ignored until the next period.
REQ-020 SHALL drive pwm_o high in RUN while counter < latched magnitude; magnitude 0 gives constant low, M gives constant high.
REQ-021 SHALL drive dir_o = latched sign XOR DIR_INV[k], with dir_o registered.
REQ-022 SHALL implement per-channel FSM with states IDLE, RUN, REVERSE, BRAKE, FAULT.
REQ-023 IDLE: pwm_o=0, br_o=0, dir_o held; goes to RUN at the next period start when en=1.
REQ-024 RUN: on a latched sign differing from current dir, goes to REVERSE without changing dir_o.
REQ-025 REVERSE: pwm_o=0, br_o=1 for exactly DEADTIME clk cycles; then updates dir_o and returns to RUN, with PWM resuming at the next period start.
REQ-026 BRAKE: entered from RUN or REVERSE when brake_i=1; pwm_o=0, br_o=1; returns to RUN at the next period start after brake_i=0.
REQ-027 FAULT: entered from any state when the synchronised therm_n_i is low for 2 consecutive cycles; pwm_o=0, br_o=1, fault_o=1.
REQ-028 FAULT SHALL exit to IDLE only on fault_clr_i=1 while the synchronised therm_n_i=1; otherwise it holds.
REQ-029 Priority SHALL be FAULT > en=0 (IDLE) > brake_i > reversal.
REQ-030 therm_n_i SHALL pass through a 2-flop synchroniser, giving a 4-cycle worst-case fault-entry latency; all outputs SHALL be registered.
REQ-031 Channels SHALL be fully independent apart from the shared counter.

Reset
REQ-032 On rst: pwm_o=0, dir_o=DIR_INV, br_o=0, fault_o=0, FSMs in IDLE, counter=0, synchronisers=1 (no fault); rst asserted mid-period SHALL take effect immediately, with no partial pulse on release.

Structure
REQ-033 The state encoding and the M/counter-width helper function SHALL live in shared package hbridge_pkg.
REQ-034 Per-channel logic SHALL be sub-module hbridge_channel, instantiated NCH times by generate; counter and prescaler SHALL stay in the top level.

Verification
REQ-035 Use NCH=2, NBITS=9, CLK_DIV=1, DEADTIME=4 (M=255). Duty +64 on ch0 -> pwm_o[0] high 64 of every 255 cycles, dir_o[0]=0.
REQ-036 Duty -256 -> saturated to 255, so pwm_o constantly high and dir_o=1; duty 0 -> pwm_o constantly low.
REQ-037 Switch +100 to -100 mid-period -> remainder of the period at 100, then br_o=1 and pwm_o=0 for 4 cycles, dir_o flips, and the next period runs at 100.
REQ-038 therm_n_i[1] low for 3 cycles -> fault_o[1]=1 within 4 cycles, br_o[1]=1; ch0 unaffected; fault_clr_i with flag still low -> stays in FAULT; clear after flag high -> IDLE, then RUN.
REQ-039 brake_i held 10 cycles, en dropped, and rst asserted mid-pulse -> outputs match REQ-026, REQ-023 and REQ-032 respectively, with no glitch on pwm_o.

Source files
------------

// File: rtl/hbridge_pkg.sv
// Shared definitions for the H-bridge driver: channel FSM state encoding and
// PWM period helpers. The period length M = 2^(NBITS-1)-1 is also the
// largest magnitude a duty word can express.
package hbridge_pkg;

    localparam int unsigned ST_W = 3;

    // Channel FSM states (plain constants so legacy tools can consume them).
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_RUN     = 3'd1;
    localparam logic [ST_W-1:0] ST_REVERSE = 3'd2;
    localparam logic [ST_W-1:0] ST_BRAKE   = 3'd3;
    localparam logic [ST_W-1:0] ST_FAULT   = 3'd4;

    // Period length / maximum magnitude for a signed duty of nbits.
    function automatic int unsigned hb_cnt_max(input int unsigned nbits);
        return (32'd1 << (nbits - 32'd1)) - 32'd1;
    endfunction

    // Width of the period counter and of a duty magnitude.
    function automatic int unsigned hb_cnt_width(input int unsigned nbits);
        return nbits - 32'd1;
    endfunction

endpackage

// File: rtl/hbridge_if.sv
// Per-channel link between the shared period timebase (master) and one
// channel controller (slave).
//   en        global enable
//   per_start one-cycle pulse on the edge where the period counter wraps to 0
//   cnt_nxt   value the period counter takes at the next edge
//   duty      signed duty request for this channel
//   brake     brake request
//   therm_n   raw (unsynchronised) active-low thermal flag
//   fault_clr fault-clear request
//   pwm/dir/br/fault  registered bridge outputs of the channel
interface hbridge_if #(
    parameter int unsigned NBITS = 9
);
    import hbridge_pkg::*;

    localparam int unsigned CW = hb_cnt_width(NBITS);

    logic             en;
    logic             per_start;
    logic [CW-1:0]    cnt_nxt;
    logic [NBITS-1:0] duty;
    logic             brake;
    logic             therm_n;
    logic             fault_clr;
    logic             pwm;
    logic             dir;
    logic             br;
    logic             fault;

    modport master (
        output en, per_start, cnt_nxt, duty, brake, therm_n, fault_clr,
        input  pwm, dir, br, fault
    );

    modport slave (
        input  en, per_start, cnt_nxt, duty, brake, therm_n, fault_clr,
        output pwm, dir, br, fault
    );

endinterface

// File: rtl/hbridge_channel.sv
// One H-bridge channel: thermal-flag synchroniser, period-start duty latch,
// IDLE/RUN/REVERSE/BRAKE/FAULT controller and registered bridge outputs.
// Ports: clk, rst (async, active-high), bus (hbridge_if slave side).
module hbridge_channel
    import hbridge_pkg::*;
#(
    parameter int unsigned NBITS    = 9,
    parameter int unsigned DEADTIME = 16,
    parameter logic        DIR_INV  = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    hbridge_if.slave bus
);

    localparam int unsigned      MW        = hb_cnt_width(NBITS);
    localparam logic [MW-1:0]    MAG_MAX   = MW'(hb_cnt_max(NBITS));
    localparam logic [NBITS-1:0] DUTY_MIN  = {1'b1, {(NBITS-1){1'b0}}};
    localparam int unsigned      DW        = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0]    DEAD_INIT = DW'(DEADTIME - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [MW-1:0]    mag_q, mag_d;
    logic             sign_q, sign_d;
    logic             dir_q, dir_d;
    logic             hold_q, hold_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic             pwm_q, pwm_d;
    logic             br_q, br_d;
    logic             fault_q, fault_d;
    logic             sync1_q, sync2_q, low_q;

    logic [NBITS-1:0] neg_c;
    logic [MW-1:0]    mag_in_c;
    logic             fault_trig_c;
    logic             tgt_dir_c;

    // Two-flop synchroniser plus one-cycle history of the synchronised flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            low_q   <= 1'b0;
        end else begin
            sync1_q <= bus.therm_n;
            sync2_q <= sync1_q;
            low_q   <= ~sync2_q;
        end
    end

    // Fault when the synchronised flag has been low for two consecutive cycles.
    assign fault_trig_c = ~sync2_q & low_q;

    // Duty magnitude; the most negative code saturates to the full period.
    always_comb begin
        neg_c    = (~bus.duty) + NBITS'(1);
        mag_in_c = bus.duty[MW-1:0];
        if (bus.duty[NBITS-1]) begin
            mag_in_c = (bus.duty == DUTY_MIN) ? MAG_MAX : neg_c[MW-1:0];
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        dead_d  = dead_q;

        if (bus.per_start) begin
            mag_d  = mag_in_c;
            sign_d = bus.duty[NBITS-1];
            hold_d = 1'b0;
        end
        tgt_dir_c = sign_d ^ DIR_INV;

        if (fault_trig_c) begin
            state_d = ST_FAULT;
        end else if (state_q == ST_FAULT) begin
            if (bus.fault_clr && sync2_q) state_d = ST_IDLE;
        end else if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.per_start) begin
                        if (tgt_dir_c != dir_q) begin
                            state_d = ST_REVERSE;
                            dead_d  = DEAD_INIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.brake) begin
                        state_d = ST_BRAKE;
                    end else if (bus.per_start && (tgt_dir_c != dir_q)) begin
                        state_d = ST_REVERSE;
                        dead_d  = DEAD_INIT;
                    end
                end
                ST_REVERSE: begin
                    if (bus.brake) begin
                        state_d = ST_BRAKE;
                    end else if (dead_q == '0) begin
                        // Flip direction now; PWM waits for a fresh period.
                        state_d = ST_RUN;
                        dir_d   = tgt_dir_c;
                        hold_d  = ~bus.per_start;
                    end else begin
                        dead_d = dead_q - DW'(1);
                    end
                end
                ST_BRAKE: begin
                    if (!bus.brake && bus.per_start) begin
                        if (tgt_dir_c != dir_q) begin
                            state_d = ST_REVERSE;
                            dead_d  = DEAD_INIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs follow the next state and next counter value so the
        // registered pins line up with the counter itself.
        pwm_d   = (state_d == ST_RUN) && !hold_d && (bus.cnt_nxt < mag_d);
        br_d    = (state_d == ST_REVERSE) || (state_d == ST_BRAKE) ||
                  (state_d == ST_FAULT);
        fault_d = (state_d == ST_FAULT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            dir_q   <= DIR_INV;
            hold_q  <= 1'b0;
            dead_q  <= '0;
            pwm_q   <= 1'b0;
            br_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
            br_q    <= br_d;
            fault_q <= fault_d;
        end
    end

    assign bus.pwm   = pwm_q;
    assign bus.dir   = dir_q;
    assign bus.br    = br_q;
    assign bus.fault = fault_q;

endmodule

// File: rtl/hbridge_driver.sv
// Multi-channel LMD18200-style H-bridge driver: shared prescaled PWM period
// counter feeding NCH independent channel controllers.
// Ports: clk, rst (async, active-high), en (global enable),
//   duty_i[k*NBITS +: NBITS] signed duty, brake_i, therm_n_i (async active-low
//   thermal flag), fault_clr_i, and registered pwm_o, dir_o, br_o, fault_o.
module hbridge_driver
    import hbridge_pkg::*;
#(
    parameter int unsigned     NCH      = 2,
    parameter int unsigned     NBITS    = 9,
    parameter int unsigned     CLK_DIV  = 1,
    parameter int unsigned     DEADTIME = 16,
    parameter logic [NCH-1:0]  DIR_INV  = {NCH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH*NBITS-1:0] duty_i,
    input  logic [NCH-1:0]       brake_i,
    input  logic [NCH-1:0]       therm_n_i,
    input  logic [NCH-1:0]       fault_clr_i,
    output logic [NCH-1:0]       pwm_o,
    output logic [NCH-1:0]       dir_o,
    output logic [NCH-1:0]       br_o,
    output logic [NCH-1:0]       fault_o
);

    localparam int unsigned CW = hb_cnt_width(NBITS);
    localparam int unsigned M  = hb_cnt_max(NBITS);
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_c;
    logic          wrap_c;

    // Prescaler and period counter 0..M-1.
    always_comb begin
        tick_c = (pre_q == PW'(CLK_DIV - 1));
        pre_d  = tick_c ? '0 : pre_q + PW'(1);
        wrap_c = tick_c && (cnt_q == CW'(M - 1));
        cnt_d  = cnt_q;
        if (tick_c) cnt_d = wrap_c ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    // One channel controller per motor.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        hbridge_if #(.NBITS(NBITS)) ch_bus ();

        assign ch_bus.en        = en;
        assign ch_bus.per_start = wrap_c;
        assign ch_bus.cnt_nxt   = cnt_d;
        assign ch_bus.duty      = duty_i[k*NBITS +: NBITS];
        assign ch_bus.brake     = brake_i[k];
        assign ch_bus.therm_n   = therm_n_i[k];
        assign ch_bus.fault_clr = fault_clr_i[k];

        assign pwm_o[k]   = ch_bus.pwm;
        assign dir_o[k]   = ch_bus.dir;
        assign br_o[k]    = ch_bus.br;
        assign fault_o[k] = ch_bus.fault;

        hbridge_channel #(
            .NBITS    (NBITS),
            .DEADTIME (DEADTIME),
            .DIR_INV  (DIR_INV[k])
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .bus (ch_bus)
        );
    end

endmodule

// File: tb/tb_hbridge_driver.sv
// Directed bench for hbridge_driver: NCH=2, NBITS=9 (M=255), CLK_DIV=1,
// DEADTIME=4, DIR_INV=2'b10.
module tb_hbridge_driver;

    localparam int unsigned NBITS = 9;
    localparam int unsigned PER   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [17:0] duty_i;
    logic [1:0]  brake_i, therm_n_i, fault_clr_i;
    logic [1:0]  pwm_o, dir_o, br_o, fault_o;

    int          total = 0;
    int          bad   = 0;
    int unsigned tb_cnt;

    always #5 clk = ~clk;

    hbridge_driver #(
        .NCH(2), .NBITS(NBITS), .CLK_DIV(1), .DEADTIME(4), .DIR_INV(2'b10)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .duty_i(duty_i), .brake_i(brake_i),
        .therm_n_i(therm_n_i), .fault_clr_i(fault_clr_i), .pwm_o(pwm_o),
        .dir_o(dir_o), .br_o(br_o), .fault_o(fault_o)
    );

    // Channel-0 view of the pins, bundled the same way the design sees them.
    hbridge_if #(.NBITS(NBITS)) mon_if ();
    assign mon_if.en        = en;
    assign mon_if.per_start = (tb_cnt == 0);
    assign mon_if.cnt_nxt   = 8'(tb_cnt);
    assign mon_if.duty      = duty_i[8:0];
    assign mon_if.brake     = brake_i[0];
    assign mon_if.therm_n   = therm_n_i[0];
    assign mon_if.fault_clr = fault_clr_i[0];
    assign mon_if.pwm       = pwm_o[0];
    assign mon_if.dir       = dir_o[0];
    assign mon_if.br        = br_o[0];
    assign mon_if.fault     = fault_o[0];

    // Reference period counter: 0..254, one step per clock.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == PER - 1) ? 0 : tb_cnt + 1;
    end

    task automatic set_duty(input int ch, input logic [8:0] v);
        duty_i[ch*9 +: 9] = v;
    endtask

    // Samples one full period (255 negedges); act selects a scripted event.
    task automatic run_period(input int act, input logic [8:0] val,
                              output int p0, output int p1, output int b0, output int b1,
                              output logic [1:0] d3, output logic [1:0] d4,
                              output logic [1:0] dlast, output int f1);
        p0 = 0; p1 = 0; b0 = 0; b1 = 0; f1 = -1;
        d3 = 2'b00; d4 = 2'b00; dlast = 2'b00;
        for (int i = 0; i < int'(PER); i++) begin
            @(negedge clk);
            p0 += int'(mon_if.pwm);
            p1 += int'(pwm_o[1]);
            b0 += int'(mon_if.br);
            b1 += int'(br_o[1]);
            if (fault_o[1] && f1 < 0) f1 = i;
            if (i == 3) d3 = dir_o;
            if (i == 4) d4 = dir_o;
            if (i == int'(PER) - 1) dlast = dir_o;
            case (act)
                1: if (i == 50) set_duty(0, val);
                2: begin if (i == 20) brake_i[0] = 1'b1; if (i == 30) brake_i[0] = 1'b0; end
                3: begin if (i == 30) en = 1'b0; if (i == 100) en = 1'b1; end
                4: begin if (i == 10) therm_n_i[1] = 1'b0; if (i == 13) therm_n_i[1] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic wait_wrap();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (tb_cnt != 0 && n < 400);
        total++; if (tb_cnt != 0) begin bad++; $display("FAIL wait_wrap: no period start within %0d cycles", n); end
    endtask

    int p0, p1, b0, b1, f1;
    logic [1:0] d3, d4, dl;

    task automatic test_reset();
        int hi = 0;
        rst = 1'b1; en = 1'b1; duty_i = '0; set_duty(0, 9'd64); set_duty(1, 9'd64);
        brake_i = '0; therm_n_i = 2'b11; fault_clr_i = '0;
        repeat (3) @(negedge clk);
        total++; if (pwm_o !== 2'b00)   begin bad++; $display("FAIL rst_pwm got=%b exp=00", pwm_o); end
        total++; if (dir_o !== 2'b10)   begin bad++; $display("FAIL rst_dir got=%b exp=10", dir_o); end
        total++; if (br_o !== 2'b00)    begin bad++; $display("FAIL rst_br got=%b exp=00", br_o); end
        total++; if (fault_o !== 2'b00) begin bad++; $display("FAIL rst_fault got=%b exp=00", fault_o); end
        rst = 1'b0;
        for (int i = 0; i < 254; i++) begin @(negedge clk); hi += int'(pwm_o != 2'b00); end
        total++; if (hi !== 0) begin bad++; $display("FAIL idle_before_start pwm_high got=%0d exp=0", hi); end
    endtask

    task automatic test_duty64();
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 64)    begin bad++; $display("FAIL duty64_p0 got=%0d exp=64", p0); end
        total++; if (p1 !== 64)    begin bad++; $display("FAIL duty64_p1 got=%0d exp=64", p1); end
        total++; if (b0 + b1 !== 0) begin bad++; $display("FAIL duty64_br got=%0d exp=0", b0 + b1); end
        total++; if (dl !== 2'b10) begin bad++; $display("FAIL duty64_dir got=%b exp=10", dl); end
    endtask

    task automatic test_reverse();
        set_duty(0, 9'd100);
        run_period(1, 9'h19C, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 100) begin bad++; $display("FAIL rev_midchange_p0 got=%0d exp=100", p0); end
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (b0 !== 4)     begin bad++; $display("FAIL rev_dead_br got=%0d exp=4", b0); end
        total++; if (p0 !== 0)     begin bad++; $display("FAIL rev_dead_pwm got=%0d exp=0", p0); end
        total++; if (d3 !== 2'b10) begin bad++; $display("FAIL rev_dir_during got=%b exp=10", d3); end
        total++; if (d4 !== 2'b11) begin bad++; $display("FAIL rev_dir_after got=%b exp=11", d4); end
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 100) begin bad++; $display("FAIL rev_next_p0 got=%0d exp=100", p0); end
        total++; if (b0 !== 0)   begin bad++; $display("FAIL rev_next_br got=%0d exp=0", b0); end
        total++; if (p1 !== 64)  begin bad++; $display("FAIL rev_ch1_p1 got=%0d exp=64", p1); end
    endtask

    task automatic test_saturate();
        set_duty(0, 9'h100);
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 255)   begin bad++; $display("FAIL sat_p0 got=%0d exp=255", p0); end
        total++; if (b0 !== 0)     begin bad++; $display("FAIL sat_br got=%0d exp=0", b0); end
        total++; if (dl !== 2'b11) begin bad++; $display("FAIL sat_dir got=%b exp=11", dl); end
    endtask

    task automatic test_zero();
        set_duty(0, 9'd0);
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (b0 !== 4)     begin bad++; $display("FAIL zero_rev_br got=%0d exp=4", b0); end
        total++; if (d4 !== 2'b10) begin bad++; $display("FAIL zero_rev_dir got=%b exp=10", d4); end
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 0) begin bad++; $display("FAIL zero_p0 got=%0d exp=0", p0); end
    endtask

    task automatic test_fault();
        set_duty(0, 9'd64);
        run_period(4, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (f1 < 11 || f1 > 14) begin bad++; $display("FAIL fault_latency idx got=%0d exp=11..14", f1); end
        total++; if (p1 !== 14)  begin bad++; $display("FAIL fault_p1 got=%0d exp=14", p1); end
        total++; if (b1 !== 241) begin bad++; $display("FAIL fault_br1 got=%0d exp=241", b1); end
        total++; if (p0 !== 64 || b0 !== 0) begin bad++; $display("FAIL fault_ch0 p0=%0d b0=%0d exp=64,0", p0, b0); end
        therm_n_i[1] = 1'b0;
        repeat (4) @(negedge clk);
        fault_clr_i[1] = 1'b1; @(negedge clk); fault_clr_i[1] = 1'b0; @(negedge clk);
        total++; if (fault_o !== 2'b10) begin bad++; $display("FAIL fault_clr_flag_low got=%b exp=10", fault_o); end
        therm_n_i[1] = 1'b1;
        repeat (4) @(negedge clk);
        fault_clr_i[1] = 1'b1; @(negedge clk); fault_clr_i[1] = 1'b0;
        total++; if (fault_o !== 2'b00 || br_o[1] !== 1'b0) begin bad++; $display("FAIL fault_clr_ok fault=%b br1=%b exp=00,0", fault_o, br_o[1]); end
        wait_wrap();
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p1 !== 64 || b1 !== 0) begin bad++; $display("FAIL fault_resume p1=%0d b1=%0d exp=64,0", p1, b1); end
    endtask

    task automatic test_brake();
        run_period(2, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 21)  begin bad++; $display("FAIL brake_p0 got=%0d exp=21", p0); end
        total++; if (b0 !== 234) begin bad++; $display("FAIL brake_br0 got=%0d exp=234", b0); end
        total++; if (p1 !== 64)  begin bad++; $display("FAIL brake_ch1 got=%0d exp=64", p1); end
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 64 || b0 !== 0) begin bad++; $display("FAIL brake_resume p0=%0d b0=%0d exp=64,0", p0, b0); end
    endtask

    task automatic test_enable();
        run_period(3, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 31 || p1 !== 31) begin bad++; $display("FAIL en_drop p0=%0d p1=%0d exp=31,31", p0, p1); end
        total++; if (b0 + b1 !== 0) begin bad++; $display("FAIL en_idle_br got=%0d exp=0", b0 + b1); end
        total++; if (dl !== 2'b10)  begin bad++; $display("FAIL en_idle_dir got=%b exp=10", dl); end
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 64) begin bad++; $display("FAIL en_resume_p0 got=%0d exp=64", p0); end
    endtask

    task automatic test_reset_mid();
        int hi = 0;
        repeat (31) @(negedge clk);
        total++; if (pwm_o !== 2'b11) begin bad++; $display("FAIL rstmid_pre_pwm got=%b exp=11", pwm_o); end
        rst = 1'b1; #1;
        total++; if (pwm_o !== 2'b00 || br_o !== 2'b00) begin bad++; $display("FAIL rstmid_async pwm=%b br=%b exp=00,00", pwm_o, br_o); end
        total++; if (dir_o !== 2'b10 || fault_o !== 2'b00) begin bad++; $display("FAIL rstmid_dir_fault dir=%b fault=%b exp=10,00", dir_o, fault_o); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 254; i++) begin @(negedge clk); hi += int'(pwm_o != 2'b00); end
        total++; if (hi !== 0) begin bad++; $display("FAIL rstmid_no_partial got=%0d exp=0", hi); end
        run_period(0, '0, p0, p1, b0, b1, d3, d4, dl, f1);
        total++; if (p0 !== 64 || p1 !== 64) begin bad++; $display("FAIL rstmid_resume p0=%0d p1=%0d exp=64,64", p0, p1); end
    endtask

    initial begin
        test_reset();
        test_duty64();
        test_reverse();
        test_saturate();
        test_zero();
        test_fault();
        test_brake();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
